sink_e: RTL
===========

SINK_E -- requirements
Module: sink_e

Interface
REQ-001 Parameter SINK_W, default 3; width of the sink ID field.
REQ-002 Parameter DEPTH, default 2; entries in the response buffer.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 io_grant_valid  in  1  Grant with a sink ID issued this cycle; registers that ID as outstanding.
REQ-006 io_grant_sink  in  SINK_W  sink ID of the issued Grant.
REQ-007 io_e_ready  out  1  block accepts an E-channel GrantAck beat.
REQ-008 io_e_valid  in  1  GrantAck beat present.
REQ-009 io_e_bits_sink  in  SINK_W  sink ID carried by the GrantAck.
REQ-010 io_resp_valid  out  1  completed-ack notification available to the MSHR side.
REQ-011 io_resp_ready  in  1  MSHR side consumes the notification.
REQ-012 io_resp_bits_sink  out  SINK_W  sink ID whose Grant is acknowledged.
REQ-013 io_outstanding  out  2^SINK_W  bitmask of sink IDs awaiting GrantAck.
REQ-014 io_err  out  1  sticky protocol error: GrantAck for a non-outstanding ID.
REQ-015 io_err_sink  out  SINK_W  sink ID of the first erroneous GrantAck since last clear.
REQ-016 io_err_clear  in  1  one-cycle pulse clearing io_err and io_err_sink.

Function
REQ-017 E handshake fires when io_e_valid and io_e_ready are both 1; io_e_ready = (buffer occupancy < DEPTH), independent of io_e_valid.
REQ-018 Accepted ack whose ID bit is set in outstanding (pre-edge value) clears that bit and enqueues the ID into the response buffer.
REQ-019 Accepted ack whose ID bit is clear: no enqueue, no bit change; io_err set; io_err_sink captured only if io_err was 0.
REQ-020 io_grant_valid sets outstanding[io_grant_sink] at the next edge; grant on an already-set ID additionally sets io_err with that ID (first-error capture rule as REQ-019).
REQ-021 Same-cycle grant and accepted ack on the same ID: ack checked against pre-edge state; set takes priority, so the bit ends 1.
REQ-022 Response buffer is FIFO ordered; no flow-through: ack accepted at cycle N gives io_resp_valid at N+1 at earliest.
REQ-023 io_resp_valid = buffer non-empty; io_resp_bits_sink = head entry; dequeue when io_resp_valid and io_resp_ready.
REQ-024 Enqueue and dequeue in the same cycle leave occupancy unchanged; when full, a dequeue does not re-enable io_e_ready in that same cycle.
REQ-025 Buffer pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH+1) bits and never exceeds DEPTH.
REQ-026 io_err_clear coincident with a new error: new error wins (io_err=1, io_err_sink=new ID).
REQ-027 io_e_bits_sink is ignored when the handshake does not fire.

Reset
REQ-028 While reset=0: outstanding=0, buffer empty, io_resp_valid=0, io_e_ready=0, io_err=0, io_err_sink=0.
REQ-029 After reset deasserts, io_e_ready=1 from the first clock edge onward.
REQ-030 Reset asserted mid-operation discards buffered entries and outstanding state immediately, without waiting for a clock edge.

Structure
REQ-031 Package sink_e_pkg holds SINK_W default, N_SINKS = 2^SINK_W, DEPTH default, and the sink ID typedef.
REQ-032 Response buffer is one sub-module, sink_e_queue (DEPTH-entry FIFO, enq/deq ready-valid); tracking and error logic live in sink_e.

Verification
REQ-033 Grant sink 5, ack sink 5 at cycle 3 -> resp_valid cycle 4 with sink 5; outstanding[5] 1 then 0.
REQ-034 Ack sink 2 with nothing outstanding -> no resp, io_err=1, io_err_sink=2; later bad ack sink 6 leaves io_err_sink=2.
REQ-035 Grants 1,3,4; three acks with resp_ready=0 -> io_e_ready low after two accepts; third accepted only after one dequeue; resp order 1,3,4.
REQ-036 Same cycle grant 7 and ack 7 while 7 outstanding -> one resp sink 7, outstanding[7] remains 1, no error.
REQ-037 Buffer holding two entries, reset pulsed low between edges -> outputs reset immediately; after release, resp_valid=0, outstanding=0, io_e_ready=1.
REQ-038 Grant on already-outstanding sink 0 plus io_err_clear same cycle -> io_err=1, io_err_sink=0.

Source files
------------

// File: rtl/sink_e_pkg.sv
// sink_e_pkg: shared defaults and sink ID type for the GrantAck sink.
package sink_e_pkg;
  localparam int DEF_SINK_W = 3;
  localparam int N_SINKS = 1 << DEF_SINK_W;
  localparam int DEF_DEPTH = 2;
  typedef logic [DEF_SINK_W-1:0] sink_id_t;
endpackage

// File: rtl/sink_e_queue.sv
// sink_e_queue: DEPTH-entry ready/valid FIFO holding acknowledged sink IDs.
module sink_e_queue
  import sink_e_pkg::*;
#(
  parameter int W = DEF_SINK_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_bits,
  output logic         deq_valid,
  input  logic         deq_ready,
  output logic [W-1:0] deq_bits
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic enq, deq;
  assign enq_ready = cnt < CW'(DEPTH);
  assign deq_valid = cnt != '0;
  assign deq_bits = mem[rp];
  assign enq = enq_valid && enq_ready;
  assign deq = deq_valid && deq_ready;
  always_ff @(posedge clock) if (enq) mem[wp] <= enq_bits;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= enq ? (wp == LAST ? '0 : wp + PW'(1)) : wp;
      rp <= deq ? (rp == LAST ? '0 : rp + PW'(1)) : rp;
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end
endmodule

// File: rtl/sink_e.sv
// sink_e: tracks outstanding Grants, matches E-channel GrantAcks and reports completions.
module sink_e
  import sink_e_pkg::*;
#(
  parameter int SINK_W = DEF_SINK_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_grant_valid,
  input  logic [SINK_W-1:0]        io_grant_sink,
  output logic                     io_e_ready,
  input  logic                     io_e_valid,
  input  logic [SINK_W-1:0]        io_e_bits_sink,
  output logic                     io_resp_valid,
  input  logic                     io_resp_ready,
  output logic [SINK_W-1:0]        io_resp_bits_sink,
  output logic [(1<<SINK_W)-1:0]   io_outstanding,
  output logic                     io_err,
  output logic [SINK_W-1:0]        io_err_sink,
  input  logic                     io_err_clear
);
  localparam int NS = 1 << SINK_W;
  logic rdy_en, q_ready, fire, ack_ok, ack_bad, grant_dup, new_err;
  logic [SINK_W-1:0] err_id;
  logic [NS-1:0] clr, set;
  assign io_e_ready = rdy_en && q_ready;
  always_comb begin
    fire = io_e_valid && io_e_ready;
    ack_ok = fire && io_outstanding[io_e_bits_sink];
    ack_bad = fire && !io_outstanding[io_e_bits_sink];
    // a re-grant is legal when the same ID is being acknowledged in this cycle
    grant_dup = io_grant_valid && io_outstanding[io_grant_sink] &&
                !(ack_ok && io_e_bits_sink == io_grant_sink);
    new_err = ack_bad || grant_dup;
    err_id = ack_bad ? io_e_bits_sink : io_grant_sink;
    clr = ack_ok ? NS'(1) << io_e_bits_sink : '0;
    set = io_grant_valid ? NS'(1) << io_grant_sink : '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_en <= 1'b0;
      io_outstanding <= '0;
      io_err <= 1'b0;
      io_err_sink <= '0;
    end else begin
      rdy_en <= 1'b1;
      io_outstanding <= (io_outstanding & ~clr) | set;
      io_err <= new_err || (io_err && !io_err_clear);
      io_err_sink <= new_err && (!io_err || io_err_clear) ? err_id :
                     io_err_clear ? '0 : io_err_sink;
    end
  end
  sink_e_queue #(.W(SINK_W), .DEPTH(DEPTH)) u_queue (
    .clock(clock),
    .reset(reset),
    .enq_valid(ack_ok),
    .enq_ready(q_ready),
    .enq_bits(io_e_bits_sink),
    .deq_valid(io_resp_valid),
    .deq_ready(io_resp_ready),
    .deq_bits(io_resp_bits_sink)
  );
endmodule
